// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_if
// Purpose  : Fetch request, byte-wide memory bus and instruction handshake.
// Revision : 1.0
// ============================================================================
interface instr_fetch_if #(
  parameter int DWIDTH = 8,
  parameter int IWIDTH = 16
);
  logic [DWIDTH-1:0] pc;
  logic              fetch_en;
  logic              flush;
  logic              mem_req;
  logic [DWIDTH-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic [IWIDTH-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              align_err;
  logic              busy;

  modport master (
    input  pc, fetch_en, flush, mem_ack, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr, instr_valid, align_err, busy
  );

  modport slave (
    output pc, fetch_en, flush, mem_ack, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr, instr_valid, align_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Fetches a 16-bit little-endian instruction as two byte reads.
// Revision : 1.0
// ============================================================================
module instr_fetch #(
  parameter int DWIDTH = 8,
  parameter int IWIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_LO = 2'd1,
    REQ_HI = 2'd2,
    VALID  = 2'd3
  } state_t;

  state_t            r_state;
  logic [DWIDTH-1:0] r_addr;
  logic [IWIDTH-1:0] r_instr;
  logic              r_mem_req;
  logic              r_instr_valid;
  logic              r_align_err;
  logic              r_busy;

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_addr;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.align_err   = r_align_err;
  assign bus.busy        = r_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_instr       <= '0;
      r_mem_req     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_align_err   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_align_err <= 1'b0;
      // Flush beats any ack or handshake in the same cycle; captured data is dropped.
      if (bus.flush) begin
        r_state       <= IDLE;
        r_mem_req     <= 1'b0;
        r_instr_valid <= 1'b0;
        r_busy        <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.fetch_en) begin
              if (bus.pc[0]) begin
                r_align_err <= 1'b1;
              end else begin
                r_addr    <= bus.pc;
                r_state   <= REQ_LO;
                r_mem_req <= 1'b1;
                r_busy    <= 1'b1;
              end
            end
          end
          REQ_LO: begin
            if (bus.mem_ack) begin
              r_instr[7:0] <= bus.mem_rdata;
              r_addr       <= r_addr + DWIDTH'(1);
              r_state      <= REQ_HI;
            end
          end
          REQ_HI: begin
            if (bus.mem_ack) begin
              r_instr[IWIDTH-1:8] <= bus.mem_rdata;
              r_state             <= VALID;
              r_mem_req           <= 1'b0;
              r_instr_valid       <= 1'b1;
            end
          end
          VALID: begin
            if (bus.instr_ready) begin
              r_instr_valid <= 1'b0;
              // An even-pc fetch accepted with the handshake chains straight into the next read.
              if (bus.fetch_en && !bus.pc[0]) begin
                r_addr    <= bus.pc;
                r_state   <= REQ_LO;
                r_mem_req <= 1'b1;
              end else begin
                r_state     <= IDLE;
                r_busy      <= 1'b0;
                r_align_err <= bus.fetch_en;
              end
            end
          end
          default: begin
            r_state       <= IDLE;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 8, giving the width of the byte address and program counter.
REQ-002 The block SHALL have parameter IWIDTH, default 16, giving the instruction width, fixed at two bytes.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 pc  input  DWIDTH  byte address of the instruction to fetch.
REQ-007 fetch_en  input  1  request to fetch the instruction at pc.
REQ-008 flush  input  1  abandon any in-flight fetch (taken branch or jump).
REQ-009 mem_req  output  1  byte read request to instruction memory.
REQ-010 mem_addr  output  DWIDTH  byte address of the current read.
REQ-011 mem_ack  input  1  memory returns mem_rdata in this cycle; sampled only while mem_req=1.
REQ-012 mem_rdata  input  8  read byte.
REQ-013 instr  output  IWIDTH  assembled instruction that feeds the datapath.
REQ-014 instr_valid  output  1  instr holds a complete instruction.
REQ-015 instr_ready  input  1  the consumer accepts instr this cycle.
REQ-016 align_err  output  1  one-cycle pulse when a fetch is requested at an odd pc.
REQ-017 busy  output  1  the state is not IDLE.

Function
REQ-018 The state machine SHALL have four states:
- IDLE
- REQ_LO
- REQ_HI
- VALID

REQ-019 All outputs SHALL be registered or decoded from the state only, with no combinational path from inputs to outputs.

REQ-020 Transitions out of IDLE SHALL be:
- fetch_en=1 with pc[0]=0: latch pc into the address register and go to REQ_LO.
- fetch_en=1 with pc[0]=1: pulse align_err for one cycle and stay in IDLE.

REQ-021 Behaviour in REQ_LO SHALL be:
- Drive mem_req=1 and mem_addr=addr.
- On mem_ack: capture mem_rdata into instr[7:0], set addr to addr+1 (modulo 2^DWIDTH), and go to REQ_HI.
- Without mem_ack: hold the state with mem_req and mem_addr unchanged, for an unbounded number of wait states.

REQ-022 Behaviour in REQ_HI SHALL be:
- Drive mem_req=1 and mem_addr=addr.
- On mem_ack: capture mem_rdata into instr[15:8] and go to VALID.
- Byte order is little-endian.

REQ-023 In VALID, instr_valid SHALL be 1, and instr SHALL stay stable until a handshake.

REQ-024 A handshake is instr_valid=1 with instr_ready=1; on a handshake the block SHALL go to IDLE, or, if fetch_en=1 with an even pc in the same cycle, go directly to REQ_LO with the new pc.

REQ-025 fetch_en SHALL be ignored in REQ_LO and REQ_HI, and ignored in VALID unless a handshake occurs in the same cycle.

REQ-026 Minimum latency SHALL be 3 cycles from fetch_en to instr_valid when mem_ack is already 1 in each request cycle; each memory wait cycle adds one cycle.

REQ-027 Flush SHALL behave as follows:
- flush=1 in any state forces IDLE at the next edge.
- instr_valid and mem_req deassert at that edge.
- A mem_ack in the flush cycle is discarded and does not update instr.
- A fetch_en in the same cycle is ignored.

REQ-028 flush SHALL take priority over a handshake and over mem_ack when they occur in the same cycle.

REQ-029 instr SHALL retain its last value outside VALID; consumers qualify instr with instr_valid.

REQ-030 pc=0xFE SHALL fetch bytes 0xFE and 0xFF; the address increment never needs to wrap for aligned pc, but SHALL wrap modulo 2^DWIDTH if it does.

Reset
REQ-031 reset=0 SHALL asynchronously force the following, regardless of the state at the time (including mid-fetch):
- state=IDLE
- mem_req=0
- mem_addr=0
- instr=0
- instr_valid=0
- align_err=0
- busy=0

REQ-032 After reset deasserts, the first fetch SHALL start only on a clock edge with fetch_en=1.

Verification
REQ-033 Bench scenario, zero-wait fetch:
- Stimulus: pc=0x10, fetch_en pulse, mem_ack=1 always, memory [0x10]=0x34, [0x11]=0x12.
- Required response: mem_addr 0x10 then 0x11; instr=0x1234 with instr_valid on cycle 3.

REQ-034 Bench scenario, wait states:
- Stimulus: mem_ack delayed by 2 cycles on each byte.
- Required response: instr_valid on cycle 7; mem_addr stable throughout each wait.

REQ-035 Bench scenario, back-pressure and back-to-back:
- Stimulus: instr_ready=0 for 4 cycles; then instr_ready=1 with fetch_en=1 and pc=0x12.
- Required response: instr constant during the stall; REQ_LO entered directly with mem_addr=0x12.

REQ-036 Bench scenario, flush:
- Stimulus: flush asserted in REQ_HI in the same cycle as mem_ack.
- Required response: IDLE next cycle; instr_valid=0; instr[15:8] unchanged.

REQ-037 Bench scenario, misaligned pc:
- Stimulus: pc=0x05 with fetch_en.
- Required response: align_err=1 for exactly one cycle; mem_req stays 0.

REQ-038 Bench scenario, reset mid-fetch:
- Stimulus: reset=0 asserted asynchronously in REQ_LO.
- Required response: all outputs zero immediately; no further mem_req until the next fetch_en.
